digit_serial_addsub: RTL
========================

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits processed per clock; WIDTH SHALL be a multiple of DIGIT (N = WIDTH/DIGIT).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request; sampled only while not busy.
REQ-006 mode  input  1  0 = subtract (X - Y - Bin), 1 = add (X + Y + Bin).
REQ-007 x  input  WIDTH  first operand, sampled with start.
REQ-008 y  input  WIDTH  second operand, sampled with start.
REQ-009 bin  input  1  borrow-in (subtract) or carry-in (add), sampled with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 result  output  WIDTH  difference or sum, mod 2^WIDTH.
REQ-013 bout  output  1  borrow-out (subtract) or carry-out (add).
REQ-014 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at edge k SHALL latch x, y, mode and bin, clear the digit counter, enter RUN and set busy=1.
REQ-017 In RUN, each edge SHALL process one DIGIT-wide slice, LSB slice first, chaining the borrow/carry into the next slice.
REQ-018 The final slice SHALL be processed on edge k+N; that edge SHALL enter DONE, set done=1, clear busy, and load result, bout and ovf together.
REQ-019 DONE SHALL last exactly one cycle; it SHALL return to IDLE (done=0) unless start=1, which SHALL begin a new operation per REQ-016.
REQ-020 start in RUN SHALL be ignored and SHALL not disturb the operation in progress.
REQ-021 Subtract: result = (x - y - bin) mod 2^WIDTH; bout = 1 iff unsigned x < y + bin.
REQ-022 Add: result = (x + y + bin) mod 2^WIDTH; bout = carry out of bit WIDTH-1.
REQ-023 ovf SHALL be 1 iff the MSB carry-in differs from the MSB carry-out of the effective addition (subtract implemented as x + ~y + ~bin).
REQ-024 result, bout and ovf SHALL hold their last values from completion until the next completion, including throughout RUN.
REQ-025 Operand inputs SHALL be don't-care except on the start-sampling edge.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, result=0, bout=0, ovf=0, and clear the counter and internal shift registers.
REQ-027 Reset during RUN SHALL abort the operation; no done pulse SHALL follow, and the first start after release SHALL behave as REQ-016.

Structure
REQ-028 A shared package SHALL hold the state typedef (IDLE/RUN/DONE) and the mode encoding constants (MODE_SUB=0, MODE_ADD=1).
REQ-029 A DIGIT-wide combinational sub-module, digit_addsub (inputs a, b, cin, mode; outputs s, cout, msb carry-in), SHALL be instantiated once and reused every cycle.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-030 Sub, x=16'hFFFF, y=16'hFFFF, bin=1 -> result=16'hFFFF, bout=1, ovf=0; done exactly 4 edges after the start edge, for one cycle.
REQ-031 Sub, x=16'h8000, y=16'h0001, bin=0 -> result=16'h7FFF, bout=0, ovf=1; add, x=16'h7FFF, y=16'h0001, bin=0 -> result=16'h8000, bout=0, ovf=1.
REQ-032 Add, x=16'hFFFF, y=16'h0001, bin=0 -> result=16'h0000, bout=1, ovf=0.
REQ-033 start pulsed with new operands in the second RUN cycle -> ignored; the original result is delivered; back-to-back start in DONE -> second done 5 cycles after the first.
REQ-034 rst_n low in the second RUN cycle -> all outputs 0 immediately; no done; next operation sub 16'h000C - 16'h0003 - 1 -> 16'h0008, bout=0.
REQ-035 Random regression for WIDTH/DIGIT = 16/4, 16/16, 8/1 against a behavioural reference model, with result, bout and ovf compared at every done.

Source files
------------

// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e  : controller states (IDLE, RUN, DONE)
//   MODE_SUB : mode encoding for X - Y - Bin
//   MODE_ADD : mode encoding for X + Y + Bin
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/digit_addsub.sv
// One DIGIT-wide slice of the adder/subtractor (purely combinational).
// Subtraction is done as a + ~b + cin, so the caller supplies the already
// inverted borrow as cin for the first slice and chains cout afterwards.
// Ports:
//   a, b  : operand slices
//   cin   : carry into bit 0 of the slice
//   mode  : MODE_ADD or MODE_SUB
//   s     : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (used for signed overflow)
module digit_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT:0]   sum;

  always_comb begin
    b_eff = (mode == MODE_ADD) ? b : ~b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
    s     = sum[DIGIT-1:0];
    cout  = sum[DIGIT];
    // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
    // without a separate (DIGIT-1)-bit adder; this also covers DIGIT == 1.
    cmsb  = s[DIGIT-1] ^ a[DIGIT-1] ^ b_eff[DIGIT-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB slice
// first, finishing a WIDTH-bit operation in WIDTH/DIGIT RUN cycles.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, accepted in IDLE or DONE
//   mode           : 0 = subtract (x - y - bin), 1 = add (x + y + bin)
//   x, y, bin      : operands and borrow/carry-in, sampled with start
//   busy           : operation in progress
//   done           : one-cycle completion pulse
//   result         : difference or sum mod 2^WIDTH (held until next completion)
//   bout           : borrow-out (subtract) or carry-out (add)
//   ovf            : two's-complement signed overflow
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_sh_q, x_sh_d;
  logic [WIDTH-1:0]   y_sh_q, y_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               mode_q, mode_d;
  logic               c_q, c_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT-1:0]   s;
  logic               cout;
  logic               cmsb;
  logic               last;

  digit_addsub #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (x_sh_q[DIGIT-1:0]),
    .b    (y_sh_q[DIGIT-1:0]),
    .cin  (c_q),
    .mode (mode_q),
    .s    (s),
    .cout (cout),
    .cmsb (cmsb)
  );

  assign last = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_sh_d   = x_sh_q;
    y_sh_d   = y_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    mode_d   = mode_q;
    c_d      = c_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          x_sh_d   = x;
          y_sh_d   = y;
          mode_d   = mode;
          // Subtract runs as x + ~y + ~bin, so the borrow enters inverted.
          c_d      = (mode == MODE_ADD) ? bin : ~bin;
          res_sh_d = '0;
        end
      end
      RUN: begin
        x_sh_d   = x_sh_q >> DIGIT;
        y_sh_d   = y_sh_q >> DIGIT;
        // Slices arrive LSB first; each enters at the top and shifts down,
        // so after N slices the first one sits at bit 0.
        res_sh_d = res_sh_q >> DIGIT;
        res_sh_d[WIDTH-1 -: DIGIT] = s;
        c_d      = cout;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d  = DONE;
          result_d = res_sh_d;
          bout_d   = (mode_q == MODE_ADD) ? cout : ~cout;
          ovf_d    = cmsb ^ cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      mode_q   <= MODE_SUB;
      c_q      <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_sh_q   <= x_sh_d;
      y_sh_q   <= y_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign bout   = bout_q;
  assign ovf    = ovf_q;

endmodule
